id_ex_stage: RTL and testbench

- ID/EX pipeline register. Sits directly downstream of the register file.
- Captures the RF read operands (read_data1/read_data2) and the decoded control for the instruction in ID, and presents them to EX one cycle later.
- Adds a WB-to-ID write-through bypass, because RF writes land only at the clock edge.
- Detects load-use hazards, inserts bubbles, and honours the EX hold and branch flush.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/hazard_detect.sv | 34 +++
 rtl/id_ex_stage.sv | 177 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types: ALU op codes, control bundle, bubble constant
package pipe_pkg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int AW = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [AW-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          alu_src;
        logic [AW-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

    // True when a write-back to idx must be seen by a reader of idx this cycle.
    function automatic logic wb_hits(input logic wen, input logic [RW-1:0] widx,
                                     input logic [RW-1:0] ridx);
        return wen && (widx != REG_ZERO) && (widx == ridx);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use detection and upstream stall request
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int RW_P = 5
) (
    input  logic            i_ex_valid,
    input  logic            i_ex_mem_read,
    input  logic [RW_P-1:0] i_ex_write_reg,
    input  logic            i_id_valid,
    input  logic            i_id_use_rs,
    input  logic            i_id_use_rt,
    input  logic [RW_P-1:0] i_id_rs,
    input  logic [RW_P-1:0] i_id_rt,
    input  logic            i_ex_hold,
    input  logic            i_flush,
    output logic            o_load_use,
    output logic            o_stall
);

    logic w_rs_dep;
    logic w_rt_dep;

    assign w_rs_dep = i_id_use_rs && (i_id_rs == i_ex_write_reg);
    assign w_rt_dep = i_id_use_rt && (i_id_rt == i_ex_write_reg);

    assign o_load_use = i_ex_valid && i_ex_mem_read
                     && (i_ex_write_reg != RW_P'(REG_ZERO))
                     && i_id_valid && (w_rs_dep || w_rt_dep);

    // A flushed instruction is dropped upstream, so there is nothing to hold for.
    assign o_stall = i_ex_hold || (o_load_use && !i_flush);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB write-through bypass and load-use bubbles (option: ID_EX_PERF_CNT_EN)
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [DW-1:0] rf_read_data1,
    input  logic [DW-1:0] rf_read_data2,
    input  logic [DW-1:0] id_imm,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic [AW-1:0] id_alu_op,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_write_reg,
    input  logic [DW-1:0] wb_write_data,
    input  logic          ex_hold,
    input  logic          flush,
    output logic          stall,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_op_a,
    output logic [DW-1:0] ex_op_b,
    output logic [DW-1:0] ex_imm,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_write_reg,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          ex_alu_src,
    output logic [AW-1:0] ex_alu_op
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]   bubble_cnt,
    output logic [31:0]   hold_cnt
`endif
);

    logic          r_valid;
    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic [DW-1:0] r_imm;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [RW-1:0] r_write_reg;
    ctrl_t         r_ctrl;

    logic          w_load_use;
    logic          w_bubble;
    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_op_b;
    logic [RW-1:0] w_write_reg;
    ctrl_t         w_id_ctrl;

    hazard_detect #(
        .RW_P (RW)
    ) u_hazard (
        .i_ex_valid     (r_valid),
        .i_ex_mem_read  (r_ctrl.mem_read),
        .i_ex_write_reg (r_write_reg),
        .i_id_valid     (id_valid),
        .i_id_use_rs    (id_use_rs),
        .i_id_use_rt    (id_use_rt),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_ex_hold      (ex_hold),
        .i_flush        (flush),
        .o_load_use     (w_load_use),
        .o_stall        (stall)
    );

    // RF writes land at the clock edge, so a same-cycle WB must be forwarded here.
    assign w_op_a = wb_hits(wb_reg_write, wb_write_reg, id_rs) ? wb_write_data : rf_read_data1;
    assign w_op_b = wb_hits(wb_reg_write, wb_write_reg, id_rt) ? wb_write_data : rf_read_data2;

    assign w_write_reg = id_reg_dst ? id_rd : id_rt;

    assign w_id_ctrl.reg_write  = id_reg_write;
    assign w_id_ctrl.mem_read   = id_mem_read;
    assign w_id_ctrl.mem_write  = id_mem_write;
    assign w_id_ctrl.mem_to_reg = id_mem_to_reg;
    assign w_id_ctrl.alu_src    = id_alu_src;
    assign w_id_ctrl.alu_op     = id_alu_op;

    assign w_bubble = flush || w_load_use || !id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_imm       <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_write_reg <= '0;
            r_ctrl      <= BUBBLE_CTRL;
        end else if (!ex_hold) begin
            if (w_bubble) begin
                r_valid     <= 1'b0;
                r_pc        <= '0;
                r_op_a      <= '0;
                r_op_b      <= '0;
                r_imm       <= '0;
                r_rs        <= '0;
                r_rt        <= '0;
                r_write_reg <= '0;
                r_ctrl      <= BUBBLE_CTRL;
            end else begin
                r_valid     <= 1'b1;
                r_pc        <= id_pc;
                r_op_a      <= w_op_a;
                r_op_b      <= w_op_b;
                r_imm       <= id_imm;
                r_rs        <= id_rs;
                r_rt        <= id_rt;
                r_write_reg <= w_write_reg;
                r_ctrl      <= w_id_ctrl;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_hold_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else begin
            if (w_load_use && !ex_hold && !flush) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (ex_hold) begin
                r_hold_cnt <= r_hold_cnt + 32'd1;
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign hold_cnt   = r_hold_cnt;
`endif

    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_op_a       = r_op_a;
    assign ex_op_b       = r_op_b;
    assign ex_imm        = r_imm;
    assign ex_rs         = r_rs;
    assign ex_rt         = r_rt;
    assign ex_write_reg  = r_write_reg;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign ex_alu_src    = r_ctrl.alu_src;
    assign ex_alu_op     = r_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_use_rs, id_use_rt;
    logic [31:0] rf_read_data1, rf_read_data2, id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
    logic [3:0]  id_alu_op;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        ex_hold, flush;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_write_reg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [3:0]  ex_alu_op;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt, hold_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .ex_hold(ex_hold), .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_use_rs = 0; id_use_rt = 0; rf_read_data1 = 0; rf_read_data2 = 0; id_imm = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        id_alu_src = 0; id_reg_dst = 0; id_alu_op = 0;
        wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
        ex_hold = 0; flush = 0;
    endtask

    task automatic drive_lw(input logic [31:0] pc, input logic [4:0] dst);
        idle_inputs();
        id_valid = 1; id_pc = pc; id_rs = 5'd1; id_rt = dst; id_use_rs = 1;
        id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1; id_imm = 32'h4;
    endtask

    task automatic drive_add(input logic [31:0] pc, input logic [4:0] rs);
        idle_inputs();
        id_valid = 1; id_pc = pc; id_rs = rs; id_rt = 5'd6; id_rd = 5'd8;
        id_use_rs = 1; id_use_rt = 1; id_reg_dst = 1; id_reg_write = 1; id_alu_op = 4'd0;
        rf_read_data1 = 32'h55; rf_read_data2 = 32'h66;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        step();
        step();
        chk("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("reset_op_a", ex_op_a, 32'd0);
        chk("reset_ctrl", {27'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src}, 32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        rst = 0;

        // Plain capture
        idle_inputs();
        id_valid = 1; id_pc = 32'h100; id_rs = 3; id_rt = 4; id_rd = 7; id_reg_dst = 1;
        id_reg_write = 1; id_alu_op = 4'd2; id_imm = 32'h5;
        rf_read_data1 = 32'h11; rf_read_data2 = 32'h22;
        step();
        chk("cap_valid", {31'b0, ex_valid}, 32'd1);
        chk("cap_op_a", ex_op_a, 32'h11);
        chk("cap_op_b", ex_op_b, 32'h22);
        chk("cap_wreg_rd", {27'b0, ex_write_reg}, 32'd7);
        chk("cap_alu_op", {28'b0, ex_alu_op}, 32'd2);
        chk("cap_pc", ex_pc, 32'h100);
        chk("cap_imm", ex_imm, 32'h5);

        // WB bypass onto rs
        id_reg_dst = 0;
        wb_reg_write = 1; wb_write_reg = 3; wb_write_data = 32'hDEAD;
        step();
        chk("byp_a", ex_op_a, 32'hDEAD);
        chk("byp_a_b_untouched", ex_op_b, 32'h22);
        chk("wreg_rt", {27'b0, ex_write_reg}, 32'd4);

        // Index 0 never bypassed
        wb_write_reg = 0; id_rs = 0; rf_read_data1 = 0;
        step();
        chk("byp_zero", ex_op_a, 32'h0);

        // WB bypass onto rt
        wb_write_reg = 4; wb_write_data = 32'hBEEF;
        step();
        chk("byp_b", ex_op_b, 32'hBEEF);

        // Load-use: lw $5 then add using $5
        drive_lw(32'h130, 5'd5);
        #1;
        chk("lw_enter_nostall", {31'b0, stall}, 32'd0);
        step();
        drive_add(32'h140, 5'd5);
        #1;
        chk("lu_stall", {31'b0, stall}, 32'd1);
        step();
        chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
        chk("lu_bubble_ctrl", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'd0);
        chk("lu_released", {31'b0, stall}, 32'd0);
        step();
        chk("lu_add_valid", {31'b0, ex_valid}, 32'd1);
        chk("lu_add_pc", ex_pc, 32'h140);
        chk("lu_add_wreg", {27'b0, ex_write_reg}, 32'd8);

        // EX hold for three cycles
        drive_add(32'h200, 5'd9);
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_stall", {31'b0, stall}, 32'd1);
            step();
            chk("hold_pc", ex_pc, 32'h140);
            chk("hold_valid", {31'b0, ex_valid}, 32'd1);
        end
        ex_hold = 0;
`ifdef ID_EX_PERF_CNT_EN
        chk("hold_cnt", hold_cnt, 32'd3);
        chk("bubble_cnt", bubble_cnt, 32'd1);
`endif
        step();
        chk("hold_release_pc", ex_pc, 32'h200);

        // Flush together with load-use
        drive_lw(32'h300, 5'd5);
        step();
        drive_add(32'h304, 5'd5);
        flush = 1;
        #1;
        chk("flush_lu_stall", {31'b0, stall}, 32'd0);
        step();
        chk("flush_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_reg_write", {31'b0, ex_reg_write}, 32'd0);

        // Reset during a load-use stall
        drive_lw(32'h400, 5'd5);
        step();
        drive_add(32'h404, 5'd5);
        #1;
        chk("rst_pre_stall", {31'b0, stall}, 32'd1);
        rst = 1;
        #1;
        chk("rst_stall_follows_eq", {31'b0, stall}, 32'd1);
        step();
        rst = 0;
        #1;
        chk("rst_clear_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_clear_pc", ex_pc, 32'h0);
        chk("rst_clear_mem_read", {31'b0, ex_mem_read}, 32'd0);
        chk("rst_stall_clear", {31'b0, stall}, 32'd0);

        // Load to $0 never creates a dependency
        drive_lw(32'h500, 5'd0);
        step();
        drive_add(32'h504, 5'd0);
        #1;
        chk("lu_r0_nostall", {31'b0, stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
